// File: rtl/mips_dec_ex_mem.sv
// rtl/mips_dec_ex_mem.sv - MIPS decode/execute/memory pipeline segment
// ID/EX, EX/MEM and MEM/WB registers; jumps resolve in decode, branches in execute.
module mips_dec_ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rf_raddr0,
  output logic [4:0]  rf_raddr1,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        jump_taken,
  output logic [31:0] jump_target,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_wdata,
  output logic        dcache_wen,
  output logic        dcache_ren,
  input  logic [31:0] dcache_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;

  logic [5:0]  opcode, funct;
  logic [31:0] pc4, imm_sext, imm_zext, br_target;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rf_raddr0 = instr[25:21];
  assign rf_raddr1 = instr[20:16];
  assign pc4       = pc + 32'd4;
  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext  = {16'h0000, instr[15:0]};
  assign br_target = pc4 + {imm_sext[29:0], 2'b00};

  alu_op_t     d_alu;
  logic [31:0] d_a, d_b, d_jtarget;
  logic [4:0]  d_dest;
  logic        d_we, d_lw, d_sw, d_beq, d_bne, d_jmp;

  always_comb begin
    d_alu     = ALU_ADD;
    d_a       = rs_data;
    d_b       = rt_data;
    d_dest    = instr[15:11];
    d_we      = 1'b0;
    d_lw      = 1'b0;
    d_sw      = 1'b0;
    d_beq     = 1'b0;
    d_bne     = 1'b0;
    d_jmp     = 1'b0;
    d_jtarget = {pc4[31:28], instr[25:0], 2'b00};
    case (opcode)
      6'h00: begin
        d_we = 1'b1;
        case (funct)
          6'h20, 6'h21: d_alu = ALU_ADD;
          6'h22, 6'h23: d_alu = ALU_SUB;
          6'h24:        d_alu = ALU_AND;
          6'h25:        d_alu = ALU_OR;
          6'h26:        d_alu = ALU_XOR;
          6'h27:        d_alu = ALU_NOR;
          6'h2A:        d_alu = ALU_SLT;
          6'h2B:        d_alu = ALU_SLTU;
          6'h00, 6'h02, 6'h03: begin
            // shifts take rt as the operand and shamt as the distance
            d_alu = (funct == 6'h00) ? ALU_SLL : (funct == 6'h02) ? ALU_SRL : ALU_SRA;
            d_a   = rt_data;
            d_b   = {27'd0, instr[10:6]};
          end
          6'h08: begin
            d_we      = 1'b0;
            d_jmp     = 1'b1;
            d_jtarget = rs_data;
          end
          default: d_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin d_alu = ALU_ADD;  d_b = imm_sext; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h0A:        begin d_alu = ALU_SLT;  d_b = imm_sext; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h0B:        begin d_alu = ALU_SLTU; d_b = imm_sext; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h0C:        begin d_alu = ALU_AND;  d_b = imm_zext; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h0D:        begin d_alu = ALU_OR;   d_b = imm_zext; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h0E:        begin d_alu = ALU_XOR;  d_b = imm_zext; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h0F: begin d_alu = ALU_PASSB; d_b = {instr[15:0], 16'h0000}; d_dest = instr[20:16]; d_we = 1'b1; end
      6'h23: begin d_b = imm_sext; d_dest = instr[20:16]; d_we = 1'b1; d_lw = 1'b1; end
      6'h2B: begin d_b = imm_sext; d_sw = 1'b1; end
      6'h04: d_beq = 1'b1;
      6'h05: d_bne = 1'b1;
      6'h02: d_jmp = 1'b1;
      6'h03: begin d_jmp = 1'b1; d_alu = ALU_PASSB; d_b = pc + 32'd8; d_dest = 5'd31; d_we = 1'b1; end
      default: ;
    endcase
  end

  logic        idex_valid, idex_we, idex_lw, idex_sw, idex_beq, idex_bne;
  alu_op_t     idex_alu;
  logic [31:0] idex_a, idex_b, idex_rt, idex_btarget;
  logic [4:0]  idex_dest;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_valid <= 1'b0; idex_we <= 1'b0; idex_lw <= 1'b0; idex_sw <= 1'b0;
      idex_beq <= 1'b0; idex_bne <= 1'b0; idex_alu <= ALU_ADD;
      idex_a <= '0; idex_b <= '0; idex_rt <= '0; idex_btarget <= '0; idex_dest <= '0;
      jump_taken <= 1'b0; jump_target <= '0;
    end else begin
      idex_valid <= instr_valid; idex_we <= d_we; idex_lw <= d_lw; idex_sw <= d_sw;
      idex_beq <= d_beq; idex_bne <= d_bne; idex_alu <= d_alu;
      idex_a <= d_a; idex_b <= d_b; idex_rt <= rt_data; idex_btarget <= br_target;
      idex_dest <= d_dest;
      jump_taken <= instr_valid & d_jmp; jump_target <= d_jtarget;
    end
  end

  logic [31:0] alu_result;
  logic        ops_equal;
  assign ops_equal = (idex_a == idex_rt);

  always_comb begin
    alu_result = '0;
    case (idex_alu)
      ALU_ADD:   alu_result = idex_a + idex_b;
      ALU_SUB:   alu_result = idex_a - idex_b;
      ALU_AND:   alu_result = idex_a & idex_b;
      ALU_OR:    alu_result = idex_a | idex_b;
      ALU_XOR:   alu_result = idex_a ^ idex_b;
      ALU_NOR:   alu_result = ~(idex_a | idex_b);
      ALU_SLT:   alu_result = {31'd0, $signed(idex_a) < $signed(idex_b)};
      ALU_SLTU:  alu_result = {31'd0, idex_a < idex_b};
      ALU_SLL:   alu_result = idex_a << idex_b[4:0];
      ALU_SRL:   alu_result = idex_a >> idex_b[4:0];
      ALU_SRA:   alu_result = $signed(idex_a) >>> idex_b[4:0];
      ALU_PASSB: alu_result = idex_b;
      default:   alu_result = '0;
    endcase
  end

  logic        exmem_valid, exmem_we, exmem_lw, exmem_sw;
  logic [31:0] exmem_result, exmem_rt;
  logic [4:0]  exmem_dest;

  always_ff @(posedge clk) begin
    if (!rst) begin
      exmem_valid <= 1'b0; exmem_we <= 1'b0; exmem_lw <= 1'b0; exmem_sw <= 1'b0;
      exmem_result <= '0; exmem_rt <= '0; exmem_dest <= '0;
      branch_taken <= 1'b0; branch_target <= '0;
    end else begin
      exmem_valid <= idex_valid; exmem_we <= idex_we; exmem_lw <= idex_lw; exmem_sw <= idex_sw;
      exmem_result <= alu_result; exmem_rt <= idex_rt; exmem_dest <= idex_dest;
      branch_taken <= idex_valid & ((idex_beq & ops_equal) | (idex_bne & ~ops_equal));
      branch_target <= idex_btarget;
    end
  end

  assign dcache_addr  = exmem_result;
  assign dcache_wdata = exmem_rt;
  assign dcache_ren   = exmem_valid & exmem_lw;
  assign dcache_wen   = exmem_valid & exmem_sw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0; wb_en <= 1'b0; wb_addr <= '0; wb_data <= '0;
    end else begin
      wb_valid <= exmem_valid;
      wb_en    <= exmem_valid & exmem_we & (exmem_dest != 5'd0);
      wb_addr  <= exmem_dest;
      wb_data  <= exmem_lw ? dcache_rdata : exmem_result;
    end
  end

endmodule

// File: tb/tb_mips_dec_ex_mem.sv
// tb/tb_mips_dec_ex_mem.sv - directed plus randomized bench for mips_dec_ex_mem
// An architectural model predicts each slot; outputs are matched per pipeline stage.
module tb_mips_dec_ex_mem;
  logic        clk = 1'b0, rst = 1'b0, instr_valid = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs_data = '0, rt_data = '0, dcache_rdata = '0;
  logic [4:0]  rf_raddr0, rf_raddr1, wb_addr;
  logic        jump_taken, branch_taken, dcache_wen, dcache_ren, wb_valid, wb_en;
  logic [31:0] jump_target, branch_target, dcache_addr, dcache_wdata, wb_data;

  mips_dec_ex_mem dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rs_data(rs_data), .rt_data(rt_data),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata), .dcache_wen(dcache_wen),
    .dcache_ren(dcache_ren), .dcache_rdata(dcache_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // kind: 0 bubble, 1 real instruction, 2 flushed by reset (all outputs zero)
  typedef struct {
    int kind; logic en; logic [4:0] dest; logic [31:0] data;
    logic lw; logic sw; logic [31:0] addr; logic [31:0] wdata;
    logic jmp; logic [31:0] jt; logic br; logic [31:0] bt;
    logic [31:0] rdata; int psel; logic [31:0] pval;
  } exp_t;

  exp_t slots [0:1023];
  int   checks = 0, errors = 0, k = 0;

  localparam logic [5:0] RFN [0:13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                        6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
  localparam logic [5:0] IOP [0:12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                        6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

  function automatic logic [31:0] r_i(input logic [5:0] fn, input logic [4:0] s, t, d, sh);
    return {6'h00, s, t, d, sh, fn};
  endfunction
  function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction
  function automatic logic [31:0] j_i(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, p, a, b, rd);
    exp_t e;
    logic [31:0] se, ze, p4;
    int sh;
    e = '{default: 0};
    e.kind = 1; e.rdata = rd;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    p4 = p + 4;
    sh = int'(ins[10:6]);
    e.dest = ins[20:16];
    e.en = 1'b1;
    case (ins[31:26])
      6'h00: begin
        e.dest = ins[15:11];
        case (ins[5:0])
          6'h20, 6'h21: e.data = a + b;
          6'h22, 6'h23: e.data = a - b;
          6'h24: e.data = a & b;
          6'h25: e.data = a | b;
          6'h26: e.data = a ^ b;
          6'h27: e.data = ~(a | b);
          6'h2A: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: e.data = (a < b) ? 32'd1 : 32'd0;
          6'h00: e.data = b << sh;
          6'h02: e.data = b >> sh;
          6'h03: e.data = b[31] ? ~((~b) >> sh) : (b >> sh);
          6'h08: begin e.en = 1'b0; e.jmp = 1'b1; e.jt = a; end
          default: e.en = 1'b0;
        endcase
      end
      6'h08, 6'h09: e.data = a + se;
      6'h0A: e.data = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
      6'h0B: e.data = (a < se) ? 32'd1 : 32'd0;
      6'h0C: e.data = a & ze;
      6'h0D: e.data = a | ze;
      6'h0E: e.data = a ^ ze;
      6'h0F: e.data = ze * 65536;
      6'h23: begin e.lw = 1'b1; e.addr = a + se; e.data = rd; end
      6'h2B: begin e.en = 1'b0; e.sw = 1'b1; e.addr = a + se; e.wdata = b; end
      6'h04: begin e.en = 1'b0; e.br = (a == b); e.bt = p4 + se * 4; end
      6'h05: begin e.en = 1'b0; e.br = (a != b); e.bt = p4 + se * 4; end
      6'h02: begin e.en = 1'b0; e.jmp = 1'b1; e.jt = {p4[31:28], ins[25:0], 2'b00}; end
      6'h03: begin e.jmp = 1'b1; e.jt = {p4[31:28], ins[25:0], 2'b00}; e.dest = 5'd31; e.data = p + 8; end
      default: e.en = 1'b0;
    endcase
    if (e.dest == 5'd0) e.en = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t j, b, w;
    j = slots[k + 3];
    b = slots[k + 2];
    w = slots[k + 1];
    chk("jump_taken", 32'(jump_taken), (j.kind == 1) ? 32'(j.jmp) : 32'd0);
    if (j.kind == 2) chk("jump_target_rst", jump_target, 32'd0);
    if (j.kind == 1 && j.jmp) chk("jump_target", jump_target, j.jt);
    if (j.kind == 1 && j.psel == 2) chk("plan_jump_target", jump_target, j.pval);
    chk("branch_taken", 32'(branch_taken), (b.kind == 1) ? 32'(b.br) : 32'd0);
    chk("dcache_ren", 32'(dcache_ren), (b.kind == 1) ? 32'(b.lw) : 32'd0);
    chk("dcache_wen", 32'(dcache_wen), (b.kind == 1) ? 32'(b.sw) : 32'd0);
    if (b.kind == 2) begin
      chk("branch_target_rst", branch_target, 32'd0);
      chk("dcache_addr_rst", dcache_addr, 32'd0);
      chk("dcache_wdata_rst", dcache_wdata, 32'd0);
    end
    if (b.kind == 1 && b.br) chk("branch_target", branch_target, b.bt);
    if (b.kind == 1 && (b.lw || b.sw)) chk("dcache_addr", dcache_addr, b.addr);
    if (b.kind == 1 && b.sw) chk("dcache_wdata", dcache_wdata, b.wdata);
    if (b.kind == 1 && b.psel == 3) chk("plan_branch_target", branch_target, b.pval);
    if (b.kind == 1 && b.psel == 4) chk("plan_dcache_addr", dcache_addr, b.pval);
    chk("wb_valid", 32'(wb_valid), (w.kind == 1) ? 32'd1 : 32'd0);
    chk("wb_en", 32'(wb_en), (w.kind == 1) ? 32'(w.en) : 32'd0);
    if (w.kind == 2) begin
      chk("wb_addr_rst", 32'(wb_addr), 32'd0);
      chk("wb_data_rst", wb_data, 32'd0);
    end
    if (w.kind == 1 && w.en) begin
      chk("wb_addr", 32'(wb_addr), 32'(w.dest));
      chk("wb_data", wb_data, w.data);
    end
    if (w.kind == 1 && w.psel == 1) chk("plan_wb_data", wb_data, w.pval);
  endtask

  // slot k is the instruction presented for edge k; slots[] is offset by 4
  task automatic step(input logic v, input logic r, input logic [31:0] ins, p, a, b, rd,
                      input int psel, input logic [31:0] pval);
    exp_t e;
    e = model(ins, p, a, b, rd);
    if (!v) e.kind = 0;
    e.psel = psel; e.pval = pval;
    slots[k + 4] = e;
    if (!r) for (int i = 0; i < 3; i++) slots[k + 4 - i].kind = 2;
    rst = r; instr_valid = v; instr = ins; pc = p; rs_data = a; rt_data = b;
    dcache_rdata = slots[k + 2].rdata;
    #1;
    chk("rf_raddr0", 32'(rf_raddr0), 32'(ins[25:21]));
    chk("rf_raddr1", 32'(rf_raddr1), 32'(ins[20:16]));
    @(posedge clk);
    k++;
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] s, t, d, sh;
    s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); sh = 5'($urandom);
    case ($urandom_range(0, 3))
      0, 1: return r_i(RFN[$urandom_range(0, 13)], s, t, d, sh);
      2:    return i_i(IOP[$urandom_range(0, 12)], s, t, 16'($urandom));
      default: return ($urandom_range(0, 1) == 0) ? j_i(6'h03, 26'($urandom)) : $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ri, ra, rb;
    for (int i = 0; i < 1024; i++) begin
      slots[i] = '{default: 0};
      slots[i].kind = 2;
    end
    step(1, 0, r_i(6'h20, 1, 2, 3, 0), 0, 5, 7, 0, 0, 0);
    step(1, 0, r_i(6'h20, 1, 2, 3, 0), 4, 5, 7, 0, 0, 0);
    step(1, 1, r_i(6'h20, 1, 2, 3, 0), 32'h0, 5, 7, 0, 1, 32'd12);
    step(1, 1, r_i(6'h22, 1, 2, 4, 0), 32'h4, 0, 1, 0, 1, 32'hFFFFFFFF);
    step(1, 1, r_i(6'h2A, 1, 2, 5, 0), 32'h8, 32'hFFFFFFFF, 1, 0, 1, 32'd1);
    step(1, 1, r_i(6'h2B, 1, 2, 5, 0), 32'hC, 32'hFFFFFFFF, 1, 0, 1, 32'd0);
    step(1, 1, r_i(6'h03, 0, 2, 6, 4), 32'h10, 0, 32'h80000000, 0, 1, 32'hF8000000);
    step(1, 1, i_i(6'h0F, 0, 7, 16'h1234), 32'h14, 0, 0, 0, 1, 32'h12340000);
    step(1, 1, i_i(6'h0D, 1, 8, 16'hFFFF), 32'h18, 0, 0, 0, 1, 32'h0000FFFF);
    step(1, 1, i_i(6'h2B, 1, 2, 16'h0008), 32'h1C, 32'h100, 32'hDEADBEEF, 0, 4, 32'h108);
    step(1, 1, i_i(6'h23, 1, 9, 16'h0008), 32'h20, 32'h100, 0, 32'hCAFE0001, 1, 32'hCAFE0001);
    step(1, 1, i_i(6'h04, 1, 2, 16'h0003), 32'h40, 5, 5, 0, 3, 32'h50);
    step(1, 1, i_i(6'h05, 1, 2, 16'h0003), 32'h44, 5, 5, 0, 0, 0);
    step(1, 1, j_i(6'h02, 26'h10), 32'h1000, 0, 0, 0, 2, 32'h40);
    step(1, 1, j_i(6'h03, 26'h10), 32'h1000, 0, 0, 0, 1, 32'h1008);
    step(1, 1, r_i(6'h08, 1, 0, 0, 0), 32'h1004, 32'h200, 0, 0, 2, 32'h200);
    step(1, 1, i_i(6'h08, 0, 0, 16'h0005), 32'h1008, 0, 0, 0, 0, 0);
    step(1, 1, {6'h3F, 26'h1234567}, 32'h100C, 1, 2, 0, 0, 0);
    step(0, 1, r_i(6'h20, 1, 2, 3, 0), 32'h1010, 1, 2, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      ri = rand_instr();
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 60) != 0), ri, $urandom, ra, rb,
           $urandom, 0, 0);
    end
    for (int n = 0; n < 4; n++) step(0, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
